// File: rtl/dma_copy_engine_pkg.sv
// Shared definitions for the DMA copy engine: memory constants, register
// offsets, access-size encodings, FSM states and small helpers.
package dma_copy_engine_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_BYTES  = MEM_DATA_W / 8;

   localparam logic [3:0] REG_SRC_OFS  = 4'h0;
   localparam logic [3:0] REG_DST_OFS  = 4'h4;
   localparam logic [3:0] REG_LEN_OFS  = 4'h8;
   localparam logic [3:0] REG_CTRL_OFS = 4'hC;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RDW,
      ST_WR,
      ST_WRW,
      ST_END
   } dma_state_t;

   // Address step per element; the reserved size never reaches a transfer.
   function automatic logic [2:0] size_to_incr(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd0;
      endcase
   endfunction

   // The reserved size is treated as never aligned so it is rejected at start.
   function automatic logic addr_misaligned(input logic [1:0] lsb, input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return lsb[0];
         SIZE_WORD: return |lsb;
         default:   return 1'b1;
      endcase
   endfunction

   // Zero the bytes above the element so write data is clean right-aligned.
   function automatic logic [31:0] mask_to_size(input logic [31:0] d, input logic [1:0] size);
      case (size)
         SIZE_BYTE: return {24'h0, d[7:0]};
         SIZE_HALF: return {16'h0, d[15:0]};
         default:   return d;
      endcase
   endfunction

endpackage

// File: rtl/dma_copy_engine_cfg_regs.sv
// Register file for the DMA copy engine: SRC/DST/LEN/CTRL storage, sticky
// status bits, registered read path and the level interrupt.
module dma_cfg_regs
   import dma_copy_engine_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cfg_addr,
   input  logic              cfg_write_en,
   input  logic [31:0]       cfg_write_data,
   input  logic              cfg_read_en,
   output logic [31:0]       cfg_read_data,
   input  logic              busy,
   input  logic [LEN_W-1:0]  remaining,
   input  logic              start_ack,
   input  logic              set_done,
   input  logic              set_error,
   input  logic              set_aborted,
   output logic [ADDR_W-1:0] reg_src,
   output logic [ADDR_W-1:0] reg_dst,
   output logic [LEN_W-1:0]  reg_len,
   output logic [1:0]        reg_size,
   output logic [1:0]        size_eff,
   output logic              start_req,
   output logic              abort_req,
   output logic              irq
);

   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1:0]        size_q, size_d;
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d, error_q, error_d, aborted_q, aborted_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        reg_sel;
   logic              wr_src, wr_dst, wr_len, wr_ctrl;
   logic [31:0]       status_w;
   logic              cfg_addr_unused;

   assign cfg_addr_unused = ^cfg_addr[1:0];

   // Decode writes, update stored fields and status, build the read word.
   always_comb begin
      reg_sel  = cfg_addr[3:2];
      wr_src   = cfg_write_en && (reg_sel == REG_SRC_OFS[3:2]);
      wr_dst   = cfg_write_en && (reg_sel == REG_DST_OFS[3:2]);
      wr_len   = cfg_write_en && (reg_sel == REG_LEN_OFS[3:2]);
      wr_ctrl  = cfg_write_en && (reg_sel == REG_CTRL_OFS[3:2]);
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      size_d   = size_q;
      irq_en_d = irq_en_q;
      if (wr_src && !busy) src_d = ADDR_W'(cfg_write_data);
      if (wr_dst && !busy) dst_d = ADDR_W'(cfg_write_data);
      if (wr_len && !busy) len_d = cfg_write_data[LEN_W-1:0];
      if (wr_ctrl) begin
         irq_en_d = cfg_write_data[4];
         if (!busy) size_d = cfg_write_data[3:2];
      end
      // Clear first so a same-cycle set always wins.
      done_d    = done_q;
      error_d   = error_q;
      aborted_d = aborted_q;
      if (start_ack || (wr_ctrl && cfg_write_data[8])) begin
         done_d    = 1'b0;
         error_d   = 1'b0;
         aborted_d = 1'b0;
      end
      if (set_done)    done_d    = 1'b1;
      if (set_error)   error_d   = 1'b1;
      if (set_aborted) aborted_d = 1'b1;
      status_w        = '0;
      status_w[0]     = busy;
      status_w[1]     = done_q;
      status_w[2]     = error_q;
      status_w[3]     = aborted_q;
      status_w[5:4]   = size_q;
      status_w[6]     = irq_en_q;
      status_w[31:16] = 16'(remaining);
      rdata_d = rdata_q;
      if (cfg_read_en) begin
         case (reg_sel)
            REG_SRC_OFS[3:2]: rdata_d = 32'(src_q);
            REG_DST_OFS[3:2]: rdata_d = 32'(dst_q);
            REG_LEN_OFS[3:2]: rdata_d = 32'(len_q);
            default:          rdata_d = status_w;
         endcase
      end
   end

   // Register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         size_q    <= SIZE_BYTE;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         aborted_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         size_q    <= size_d;
         irq_en_q  <= irq_en_d;
         done_q    <= done_d;
         error_q   <= error_d;
         aborted_q <= aborted_d;
         rdata_q   <= rdata_d;
      end
   end

   assign cfg_read_data = rdata_q;
   assign reg_src       = src_q;
   assign reg_dst       = dst_q;
   assign reg_len       = len_q;
   assign reg_size      = size_q;
   // A start that carries a new size must be checked against that size.
   assign size_eff      = (wr_ctrl && !busy) ? cfg_write_data[3:2] : size_q;
   assign start_req     = wr_ctrl && cfg_write_data[0];
   assign abort_req     = wr_ctrl && cfg_write_data[1];
   assign irq           = irq_en_q && (done_q || error_q || aborted_q);

endmodule

// File: rtl/dma_copy_engine.sv
// Memory-to-memory copy initiator: alternates single-element reads and
// writes on the dmem port until the count expires, an abort, or a fault.
//
//   state | meaning
//   IDLE  | waiting for start; checks length and alignment
//   RD    | issue read of src when dmem_ready
//   RDW   | read result/fault cycle; capture element
//   WR    | issue write to dst when dmem_ready
//   WRW   | write fault cycle; advance pointers and count
//   END   | busy dropped; back to IDLE next cycle
module dma_copy_engine
   import dma_copy_engine_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cfg_addr,
   input  logic              cfg_write_en,
   input  logic [31:0]       cfg_write_data,
   input  logic              cfg_read_en,
   output logic [31:0]       cfg_read_data,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [1:0]        dmem_size,
   output logic              dmem_read_en,
   output logic              dmem_write_en,
   output logic [31:0]       dmem_write_data,
   input  logic [31:0]       dmem_read_data,
   input  logic              dmem_ready,
   input  logic              fault,
   output logic              irq
);

   dma_state_t        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] reg_src, reg_dst;
   logic [LEN_W-1:0]  reg_len;
   logic [1:0]        reg_size, size_eff;
   logic              start_req, abort_req, start_ack;
   logic              set_done, set_error, set_aborted;
   logic              busy;
   logic [ADDR_W-1:0] step;

   assign busy = (state_q != ST_IDLE) && (state_q != ST_END);
   assign step = ADDR_W'(size_to_incr(reg_size));

   dma_cfg_regs #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) u_regs (
      .clk            (clk),
      .rst            (rst),
      .cfg_addr       (cfg_addr),
      .cfg_write_en   (cfg_write_en),
      .cfg_write_data (cfg_write_data),
      .cfg_read_en    (cfg_read_en),
      .cfg_read_data  (cfg_read_data),
      .busy           (busy),
      .remaining      (cnt_q),
      .start_ack      (start_ack),
      .set_done       (set_done),
      .set_error      (set_error),
      .set_aborted    (set_aborted),
      .reg_src        (reg_src),
      .reg_dst        (reg_dst),
      .reg_len        (reg_len),
      .reg_size       (reg_size),
      .size_eff       (size_eff),
      .start_req      (start_req),
      .abort_req      (abort_req),
      .irq            (irq)
   );

   // Next-state, datapath and dmem request generation.
   always_comb begin
      state_d         = state_q;
      src_d           = src_q;
      dst_d           = dst_q;
      cnt_d           = cnt_q;
      data_d          = data_q;
      dmem_read_en    = 1'b0;
      dmem_write_en   = 1'b0;
      dmem_addr       = '0;
      dmem_size       = SIZE_BYTE;
      dmem_write_data = '0;
      start_ack       = 1'b0;
      set_done        = 1'b0;
      set_error       = 1'b0;
      set_aborted     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               start_ack = 1'b1;
               src_d     = reg_src;
               dst_d     = reg_dst;
               cnt_d     = reg_len;
               if (reg_len == '0) begin
                  set_done = 1'b1;
               end else if (addr_misaligned(reg_src[1:0], size_eff) ||
                            addr_misaligned(reg_dst[1:0], size_eff)) begin
                  set_error = 1'b1;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (abort_req) begin
               set_aborted = 1'b1;
               state_d     = ST_END;
            end else if (dmem_ready) begin
               dmem_read_en = 1'b1;
               dmem_addr    = src_q;
               dmem_size    = reg_size;
               state_d      = ST_RDW;
            end
         end
         ST_RDW: begin
            if (fault) begin
               set_error = 1'b1;
               state_d   = ST_END;
            end else if (abort_req) begin
               set_aborted = 1'b1;
               state_d     = ST_END;
            end else begin
               data_d  = mask_to_size(dmem_read_data, reg_size);
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            if (abort_req) begin
               set_aborted = 1'b1;
               state_d     = ST_END;
            end else if (dmem_ready) begin
               dmem_write_en   = 1'b1;
               dmem_addr       = dst_q;
               dmem_size       = reg_size;
               dmem_write_data = data_q;
               state_d         = ST_WRW;
            end
         end
         ST_WRW: begin
            if (fault) begin
               set_error = 1'b1;
               state_d   = ST_END;
            end else if (abort_req) begin
               set_aborted = 1'b1;
               state_d     = ST_END;
            end else begin
               cnt_d = cnt_q - LEN_W'(1);
               src_d = src_q + step;
               dst_d = dst_q + step;
               if (cnt_q == LEN_W'(1)) begin
                  set_done = 1'b1;
                  state_d  = ST_END;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any request immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

endmodule
